// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and hazard-control response bundle between the in-order pipeline
// and hazard_scoreboard. The pipeline side is master; the scoreboard side is slave.
interface hazard_scoreboard_if #(
  parameter int RAW   = 5,
  parameter int SW    = 2,
  parameter int CNT_W = 16
);
  logic           id_valid;
  logic [RAW-1:0] id_rs1;
  logic [RAW-1:0] id_rs2;
  logic           id_rs1_used;
  logic           id_rs2_used;
  logic           id_rf_we;
  logic [RAW-1:0] id_wR;
  logic           id_is_load;
  logic           ex_redirect;

  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [SW-1:0]    fwd_sel1;
  logic [SW-1:0]    fwd_sel2;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rf_we, id_wR, id_is_load, ex_redirect,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
           fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rf_we, id_wR, id_is_load, ex_redirect,
    output pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
           fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard, forwarding and flush controller: tracks in-flight RF writes from EX to WB
// and derives stall/bubble/flush controls, operand forwarding selects and event counters.
module hazard_scoreboard #(
  parameter int NSTAGE   = 3,
  parameter int RAW      = 5,
  parameter int LOAD_LAT = 2,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  hazard_scoreboard_if.slave hz
);
  localparam int SW = $clog2(NSTAGE + 1);

  typedef struct packed {
    logic          hit;
    logic          ld;
    logic [SW-1:0] k;
  } match_t;

  // Entry k mirrors the pipeline register k stages past ID (1 = ID/EX, NSTAGE = MEM/WB).
  logic [NSTAGE:1] e_vld;
  logic [NSTAGE:1] e_we;
  logic [NSTAGE:1] e_ld;
  logic [RAW-1:0]  e_rd [1:NSTAGE];

  match_t           m1;
  match_t           m2;
  logic             hz1;
  logic             hz2;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
    if (en && (cnt != {CNT_W{1'b1}}))
      return cnt + CNT_W'(1);
    return cnt;
  endfunction

  function automatic logic is_hazard(input match_t m);
    if (FWD_EN != 0)
      return m.hit && m.ld && (int'(m.k) < LOAD_LAT);
    return m.hit;
  endfunction

  function automatic logic [SW-1:0] fwd_of(input match_t m);
    if ((FWD_EN != 0) && m.hit && !is_hazard(m))
      return m.k;
    return '0;
  endfunction

  // Youngest writer wins: scan oldest to youngest so the smallest k is assigned last.
  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (e_vld[k] && e_we[k] && (e_rd[k] == hz.id_rs1)) begin
        m1.hit = 1'b1;
        m1.ld  = e_ld[k];
        m1.k   = SW'(k);
      end
      if (e_vld[k] && e_we[k] && (e_rd[k] == hz.id_rs2)) begin
        m2.hit = 1'b1;
        m2.ld  = e_ld[k];
        m2.k   = SW'(k);
      end
    end
    if (!hz.id_rs1_used || (hz.id_rs1 == '0)) m1 = '0;
    if (!hz.id_rs2_used || (hz.id_rs2 == '0)) m2 = '0;
  end

  assign hz1 = is_hazard(m1);
  assign hz2 = is_hazard(m2);

  // A redirect kills the ID instruction, so any hazard it carries is irrelevant.
  always_comb begin
    stall  = hz.id_valid && (hz1 || hz2) && !hz.ex_redirect;
    bubble = stall || hz.ex_redirect;

    hz.pc_stall     = stall;
    hz.if_id_stall  = stall;
    hz.if_id_flush  = hz.ex_redirect;
    hz.id_ex_bubble = bubble;
    hz.fwd_sel1     = fwd_of(m1);
    hz.fwd_sel2     = fwd_of(m2);
    hz.stall_cnt    = stall_cnt_q;
    hz.flush_cnt    = flush_cnt_q;
  end

  // ID -> EX boundary: valid bits shift with async clear.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      e_vld <= '0;
    end else begin
      e_vld <= {e_vld[NSTAGE-1:1], hz.id_valid && !bubble};
    end
  end

  always_ff @(posedge cpu_clk) begin
    e_we    <= {e_we[NSTAGE-1:1], hz.id_rf_we};
    e_ld    <= {e_ld[NSTAGE-1:1], hz.id_is_load};
    e_rd[1] <= hz.id_wR;
    for (int k = 2; k <= NSTAGE; k++)
      e_rd[k] <= e_rd[k-1];
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= sat_inc(stall_cnt_q, stall);
      flush_cnt_q <= sat_inc(flush_cnt_q, hz.ex_redirect);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (forwarding, stall-only, 4-bit counters)
// share one ID stimulus; expectations are queued with the stimulus and drained mid-cycle.
module tb_hazard_scoreboard;
  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  always #5 cpu_clk = ~cpu_clk;

  hazard_scoreboard_if #(.RAW(5), .SW(2), .CNT_W(16)) ifa ();
  hazard_scoreboard_if #(.RAW(5), .SW(2), .CNT_W(16)) ifb ();
  hazard_scoreboard_if #(.RAW(5), .SW(2), .CNT_W(4))  ifc ();

  hazard_scoreboard #(.NSTAGE(3), .RAW(5), .LOAD_LAT(2), .FWD_EN(1), .CNT_W(16))
    dut_a (.cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .hz(ifa));
  hazard_scoreboard #(.NSTAGE(3), .RAW(5), .LOAD_LAT(2), .FWD_EN(0), .CNT_W(16))
    dut_b (.cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .hz(ifb));
  hazard_scoreboard #(.NSTAGE(3), .RAW(5), .LOAD_LAT(2), .FWD_EN(1), .CNT_W(4))
    dut_c (.cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .hz(ifc));

  logic       t_valid, t_u1, t_u2, t_we, t_ld, t_redir;
  logic [4:0] t_rs1, t_rs2, t_wr;

  always_comb begin
    ifa.id_valid = t_valid; ifa.id_rs1 = t_rs1; ifa.id_rs2 = t_rs2;
    ifa.id_rs1_used = t_u1; ifa.id_rs2_used = t_u2; ifa.id_rf_we = t_we;
    ifa.id_wR = t_wr; ifa.id_is_load = t_ld; ifa.ex_redirect = t_redir;
    ifb.id_valid = t_valid; ifb.id_rs1 = t_rs1; ifb.id_rs2 = t_rs2;
    ifb.id_rs1_used = t_u1; ifb.id_rs2_used = t_u2; ifb.id_rf_we = t_we;
    ifb.id_wR = t_wr; ifb.id_is_load = t_ld; ifb.ex_redirect = t_redir;
    ifc.id_valid = t_valid; ifc.id_rs1 = t_rs1; ifc.id_rs2 = t_rs2;
    ifc.id_rs1_used = t_u1; ifc.id_rs2_used = t_u2; ifc.id_rf_we = t_we;
    ifc.id_wR = t_wr; ifc.id_is_load = t_ld; ifc.ex_redirect = t_redir;
  end

  localparam int S_PC_A = 0, S_IFS_A = 1, S_FL_A = 2, S_BUB_A = 3, S_F1_A = 4,
                 S_F2_A = 5, S_SC_A = 6, S_FC_A = 7, S_PC_B = 8, S_F1_B = 9,
                 S_SC_B = 10, S_FC_B = 11, S_PC_C = 12, S_SC_C = 13;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int obs(input int sel);
    case (sel)
      S_PC_A:  return int'(ifa.pc_stall);
      S_IFS_A: return int'(ifa.if_id_stall);
      S_FL_A:  return int'(ifa.if_id_flush);
      S_BUB_A: return int'(ifa.id_ex_bubble);
      S_F1_A:  return int'(ifa.fwd_sel1);
      S_F2_A:  return int'(ifa.fwd_sel2);
      S_SC_A:  return int'(ifa.stall_cnt);
      S_FC_A:  return int'(ifa.flush_cnt);
      S_PC_B:  return int'(ifb.pc_stall);
      S_F1_B:  return int'(ifb.fwd_sel1);
      S_SC_B:  return int'(ifb.stall_cnt);
      S_FC_B:  return int'(ifb.flush_cnt);
      S_PC_C:  return int'(ifc.pc_stall);
      S_SC_C:  return int'(ifc.stall_cnt);
      default: return -1;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    exp_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic settle();
    #3;
    check_now();
  endtask

  task automatic nxt();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic we,
                        input logic [4:0] wr, input logic ld, input logic redir);
    t_valid = v; t_rs1 = rs1; t_u1 = u1; t_rs2 = rs2; t_u2 = u2;
    t_we = we; t_wr = wr; t_ld = ld; t_redir = redir;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic apply_rst();
    @(posedge cpu_clk);
    #1;
    cpu_rst = 1'b0;
    idle();
    #1;
  endtask

  task automatic release_rst();
    @(posedge cpu_clk);
    #1;
    cpu_rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_st;
    logic st;
    idle();
    #2 cpu_rst = 1'b0;
    #1;
    push_exp("rst_pc", S_PC_A, 0);   push_exp("rst_ifs", S_IFS_A, 0);
    push_exp("rst_fl", S_FL_A, 0);   push_exp("rst_bub", S_BUB_A, 0);
    push_exp("rst_f1", S_F1_A, 0);   push_exp("rst_f2", S_F2_A, 0);
    push_exp("rst_sc", S_SC_A, 0);   push_exp("rst_fc", S_FC_A, 0);
    push_exp("rst_pc_b", S_PC_B, 0); push_exp("rst_sc_b", S_SC_B, 0);
    check_now();
    t_redir = 1'b1;
    #1;
    push_exp("rst_redir_fl", S_FL_A, 1); push_exp("rst_redir_bub", S_BUB_A, 1);
    push_exp("rst_redir_pc", S_PC_A, 0);
    check_now();
    t_redir = 1'b0;
    release_rst();

    // forwarding from EX then MEM
    set_in(1, 5'd1, 1, 5'd2, 1, 1, 5'd5, 0, 0);
    push_exp("add5_pc", S_PC_A, 0); push_exp("add5_f1", S_F1_A, 0);
    settle();
    nxt(); set_in(1, 5'd5, 1, 5'd5, 1, 1, 5'd6, 0, 0);
    push_exp("fwd1_f1", S_F1_A, 1); push_exp("fwd1_f2", S_F2_A, 1);
    push_exp("fwd1_pc", S_PC_A, 0); push_exp("fwd1_bub", S_BUB_A, 0);
    settle();
    nxt(); set_in(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0);
    push_exp("fwd2_f1", S_F1_A, 2); push_exp("fwd2_f2", S_F2_A, 0);
    push_exp("fwd2_pc", S_PC_A, 0);
    settle();

    // load-use: one stall cycle, then forward from MEM
    nxt(); set_in(1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 1, 0);
    push_exp("lw_pc", S_PC_A, 0); push_exp("lw_f1", S_F1_A, 0);
    settle();
    nxt(); set_in(1, 5'd5, 1, 5'd0, 1, 1, 5'd6, 0, 0);
    push_exp("lu_pc", S_PC_A, 1);  push_exp("lu_ifs", S_IFS_A, 1);
    push_exp("lu_bub", S_BUB_A, 1); push_exp("lu_fl", S_FL_A, 0);
    push_exp("lu_f1", S_F1_A, 0);  push_exp("lu_f2", S_F2_A, 0);
    push_exp("lu_sc0", S_SC_A, 0);
    settle();
    nxt();
    push_exp("lu2_pc", S_PC_A, 0); push_exp("lu2_bub", S_BUB_A, 0);
    push_exp("lu2_f1", S_F1_A, 2); push_exp("lu2_sc", S_SC_A, 1);
    settle();

    // youngest writer wins; x0 never matches
    nxt(); set_in(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 0);
    push_exp("w7a_pc", S_PC_A, 0); settle();
    nxt();
    push_exp("w7b_pc", S_PC_A, 0); settle();
    nxt(); set_in(1, 5'd7, 1, 5'd0, 1, 1, 5'd0, 1, 0);
    push_exp("young_f1", S_F1_A, 1); push_exp("young_f2", S_F2_A, 0);
    push_exp("young_pc", S_PC_A, 0);
    settle();
    nxt(); set_in(1, 5'd0, 1, 5'd0, 1, 1, 5'd8, 0, 0);
    push_exp("x0_pc", S_PC_A, 0); push_exp("x0_f1", S_F1_A, 0);
    push_exp("x0_f2", S_F2_A, 0);
    settle();

    // redirect beats a load-use hazard
    nxt(); set_in(1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 1, 0);
    push_exp("lw5_pc", S_PC_A, 0); settle();
    nxt(); set_in(1, 5'd5, 1, 5'd0, 0, 1, 5'd9, 1, 1);
    push_exp("rd_fl", S_FL_A, 1);  push_exp("rd_bub", S_BUB_A, 1);
    push_exp("rd_pc", S_PC_A, 0);  push_exp("rd_ifs", S_IFS_A, 0);
    push_exp("rd_sc", S_SC_A, 1);  push_exp("rd_fc0", S_FC_A, 0);
    settle();
    nxt(); set_in(1, 5'd9, 1, 5'd5, 1, 0, 5'd0, 0, 0);
    push_exp("rd2_pc", S_PC_A, 0); push_exp("rd2_f1", S_F1_A, 0);
    push_exp("rd2_f2", S_F2_A, 2); push_exp("rd2_fc", S_FC_A, 1);
    push_exp("rd2_sc", S_SC_A, 1);
    settle();

    // stall-only: NSTAGE-cycle dependency penalty
    apply_rst();
    push_exp("b_rst_sc", S_SC_B, 0); push_exp("a_rst_fc", S_FC_A, 0);
    check_now();
    release_rst();
    set_in(1, 5'd1, 1, 5'd2, 1, 1, 5'd5, 0, 0);
    push_exp("so_add_pc", S_PC_B, 0); settle();
    for (int i = 0; i < 3; i++) begin
      nxt();
      if (i == 0) set_in(1, 5'd5, 1, 5'd5, 1, 1, 5'd6, 0, 0);
      push_exp("so_st_pc", S_PC_B, 1); push_exp("so_st_f1", S_F1_B, 0);
      push_exp("so_st_sc", S_SC_B, i);
      settle();
    end
    nxt();
    push_exp("so_go_pc", S_PC_B, 0); push_exp("so_go_f1", S_F1_B, 0);
    push_exp("so_go_sc", S_SC_B, 3); push_exp("so_go_fc", S_FC_B, 0);
    settle();

    // async reset during the second stall cycle
    apply_rst();
    release_rst();
    set_in(1, 5'd1, 1, 5'd2, 1, 1, 5'd5, 0, 0);
    settle();
    nxt(); set_in(1, 5'd5, 1, 5'd5, 1, 1, 5'd6, 0, 0);
    push_exp("sr_st1", S_PC_B, 1); settle();
    nxt();
    push_exp("sr_st2", S_PC_B, 1); push_exp("sr_sc1", S_SC_B, 1); settle();
    cpu_rst = 1'b0;
    #1;
    push_exp("sr_pc", S_PC_B, 0); push_exp("sr_f1", S_F1_B, 0);
    push_exp("sr_sc", S_SC_B, 0); push_exp("sr_fc", S_FC_B, 0);
    check_now();
    idle();

    // repeated self-dependent loads: stalls every other cycle
    release_rst();
    set_in(1, 5'd5, 1, 5'd0, 0, 1, 5'd5, 1, 0);
    n_st = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) nxt();
      st = (i % 2) == 1;
      push_exp("sat_pc", S_PC_C, int'(st));
      push_exp("sat_sc", S_SC_C, (n_st > 15) ? 15 : n_st);
      settle();
      if (st) n_st++;
    end
    nxt();
    push_exp("sat_sc_c", S_SC_C, 15); push_exp("sat_sc_a", S_SC_A, 20);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard, forwarding and flush controller for the in-order RISC-V pipeline. It tracks every in-flight register write from EX through WB in an internal scoreboard shift register. From that state it generates stall, bubble, flush and per-operand forwarding selects for the ID stage, and keeps saturating stall/flush event counters. It sits beside the pipeline registers and drives their stall/flush pins and the EX operand muxes.

## Interface

- NSTAGE, 3, scoreboard depth = number of RF-writing stages after ID (1 = EX … NSTAGE = WB); legal 2..6
- RAW, 5, register address width
- LOAD_LAT, 2, first stage index at which load data is forwardable (2 = MEM output)
- FWD_EN, 1, 1 = forwarding mode; 0 = stall-only mode
- CNT_W, 16, event counter width
- SW = $clog2(NSTAGE+1), derived width of forwarding selects

Ports (all inputs are sampled from the ID stage unless noted):

- cpu_clk  in  1  clock, rising-edge
- cpu_rst  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  RAW  source register numbers
- id_rs1_used, id_rs2_used  in  1  operand actually read
- id_rf_we  in  1  instruction writes RF
- id_wR  in  RAW  destination register
- id_is_load  in  1  RF write data comes from DRAM
- ex_redirect  in  1  EX resolved a taken branch or jump
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID register
- if_id_flush  out  1  clear IF/ID to a bubble
- id_ex_bubble  out  1  load a bubble into ID/EX
- fwd_sel1, fwd_sel2  out  SW  operand source: 0 = RF, k = result of stage k
- stall_cnt  out  CNT_W  cycles with pc_stall = 1, saturating
- flush_cnt  out  CNT_W  cycles with ex_redirect = 1, saturating

## Operation

- The scoreboard holds entries e[1..NSTAGE], each {v, we, rd, ld}. e[1] mirrors ID/EX and e[NSTAGE] mirrors MEM/WB.
- Matching for source rs: the source must have used = 1 and rs ≠ 0. The match is the smallest k with e[k].v & e[k].we & e[k].rd == rs, i.e. the youngest writer. Writes to x0 never match.
- Forwarding mode (FWD_EN = 1):
  - No match: fwd_sel = 0.
  - Match k with e[k].ld = 1 and k < LOAD_LAT: load-use hazard. Raise a stall and force fwd_sel = 0.
  - Otherwise: fwd_sel = k.
- Stall-only mode (FWD_EN = 0): any match in 1..NSTAGE raises a stall. fwd_sel is constantly 0.
- A stall is hz1 | hz2, gated by id_valid. On a stall:
  - pc_stall = if_id_stall = id_ex_bubble = 1.
  - if_id_flush = 0.
- Redirect has priority over stall. When ex_redirect = 1:
  - if_id_flush = id_ex_bubble = 1.
  - pc_stall = if_id_stall = 0.
  - Any hazard is suppressed.
- Every posedge performs a scoreboard update:
  - e[k+1] ← e[k] for k = 1..NSTAGE-1. e[NSTAGE] retires.
  - e[1] ← bubble (v = 0) if id_ex_bubble, else {id_valid, id_rf_we, id_wR, id_is_load}.
- Counters:
  - stall_cnt increments when pc_stall = 1.
  - flush_cnt increments when ex_redirect = 1.
  - Both hold at 2^CNT_W − 1.

## Timing

- All control outputs and fwd_sel are combinational from the scoreboard state and the current-cycle inputs. Zero cycles of latency.
- The scoreboard and counters are registered, so an event is visible one cycle after the edge that captures it.
- Load-use penalty with defaults is exactly 1 cycle. In general it is LOAD_LAT − k cycles.
- Stall-only penalty for a back-to-back dependency is NSTAGE cycles.
- A redirect costs 2 bubbles: IF/ID and ID/EX.
- On reset assertion (async, at any time, including mid-stall):
  - All e[k].v = 0.
  - Both counters = 0.
  - Resulting outputs: pc_stall, if_id_stall, id_ex_bubble, fwd_sel1/2 = 0.
  - if_id_flush = id_ex_bubble = ex_redirect, so 0 with inputs idle.
- Release of reset is synchronised by the top-level reset logic. The block resumes on the first posedge after release.
- A simultaneous stall and redirect counts only toward flush_cnt.

## Test plan

- FWD_EN = 1: add x5 followed immediately by add x6,x5,x5. Required: fwd_sel1 = fwd_sel2 = 1 and no stall. One cycle later, an instruction reading x5 gets fwd_sel = 2.
- lw x5 followed by add x6,x5,x0. Required: pc_stall, if_id_stall and id_ex_bubble are high for exactly 1 cycle, stall_cnt = 1. On the next cycle fwd_sel1 = 2 with no stall.
- Writers to x7 in both e[1] and e[2], ID reads x7. Required: fwd_sel = 1 (youngest). Separately, ID reads x0 while x0 is pending: no stall, fwd_sel = 0.
- ex_redirect = 1 in the same cycle as a load-use hazard. Required: if_id_flush = id_ex_bubble = 1, pc_stall = 0, flush_cnt = 1, stall_cnt unchanged, e[1].v = 0 next cycle.
- FWD_EN = 0, NSTAGE = 3: dependent add. Required: stall for 3 consecutive cycles, then proceed with fwd_sel = 0. Assert cpu_rst low during the 2nd stall cycle: stall drops immediately and counters read 0.
- CNT_W = 4: hold a hazard for 20 cycles. Required: stall_cnt saturates at 15.
